// File: rtl/dct_noc_pkg.sv
// Shared constants, FSM state type and PE id helpers for the DCT block dispatcher.
package dct_noc_pkg;
  localparam int X           = 2;
  localparam int Y           = 2;
  localparam int data_width  = 256;
  localparam int pck_num     = 3;
  localparam int x_size      = $clog2(X);
  localparam int y_size      = $clog2(Y);
  localparam int total_width = x_size + y_size + pck_num + data_width;
  localparam int pe_num      = X * Y;
  localparam int pe_w        = $clog2(pe_num);

  typedef enum logic [1:0] {IDLE, SELECT, STREAM} dispatch_state_e;

  // PE ids are row-major: id = y*X + x.
  function automatic logic [x_size-1:0] pe_x(input logic [pe_w-1:0] id);
    return x_size'(int'(id) % X);
  endfunction

  function automatic logic [y_size-1:0] pe_y(input logic [pe_w-1:0] id);
    return y_size'(int'(id) / X);
  endfunction
endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin search for the first idle PE at or after rr_ptr_i.
module rr_free_picker
  import dct_noc_pkg::*;
(
  input  logic [pe_num-1:0] busy_i,
  input  logic [pe_w-1:0]   rr_ptr_i,
  output logic              found_o,
  output logic [pe_w-1:0]   id_o
);

  function automatic logic [pe_w-1:0] wrapIdx(input logic [pe_w-1:0] base, input int off);
    return pe_w'((int'(base) + off) % pe_num);
  endfunction

  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    for (int i = 0; i < pe_num; i++) begin
      if (!found_o && !busy_i[wrapIdx(rr_ptr_i, i)]) begin
        found_o = 1'b1;
        id_o    = wrapIdx(rr_ptr_i, i);
      end
    end
  end

endmodule

// File: rtl/dct_block_dispatcher.sv
// Groups 8 PCIe rows into a DCT block and streams it as NoC flits to a free PE.
// Build macro DCT_DISPATCH_STATS_EN enables the block/stall counters.
module dct_block_dispatcher
  import dct_noc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid,
  input  logic [data_width-1:0]  i_data,
  output logic                   o_ready,
  output logic                   o_valid_noc,
  output logic [total_width-1:0] o_data_noc,
  input  logic                   i_ready_noc,
  input  logic                   i_done_valid,
  input  logic [pe_w-1:0]        i_done_pe,
  output logic [pe_num-1:0]      o_busy_pe,
  output logic                   o_err,
  output logic [31:0]            o_blocks_sent,
  output logic [31:0]            o_stall_cycles
);

  dispatch_state_e      state_q;
  logic [pe_w-1:0]      cur_pe_q;
  logic [pe_w-1:0]      rr_ptr_q;
  logic [pck_num-1:0]   row_cnt_q;
  logic                 valid_q;
  logic [total_width-1:0] data_q;
  logic [pe_num-1:0]    busy_q, busy_d;
  logic                 err_q;

  logic                 pick_found;
  logic [pe_w-1:0]      pick_id;
  logic [pe_w-1:0]      rr_ptr_d;
  logic                 accept;
  logic                 last_row;
  logic                 err_hit;

  rr_free_picker u_picker (
    .busy_i   (busy_q),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .id_o     (pick_id)
  );

  assign o_ready  = (state_q == STREAM) && (!valid_q || i_ready_noc);
  assign accept   = i_valid && o_ready;
  assign last_row = accept && (row_cnt_q == '1);
  assign err_hit  = i_done_valid && !busy_q[i_done_pe];
  assign rr_ptr_d = (pick_id == pe_w'(pe_num - 1)) ? '0 : pick_id + 1'b1;

  // A completion and a block launch on different PEs in the same cycle both take effect.
  always_comb begin
    busy_d = busy_q;
    if (i_done_valid && busy_q[i_done_pe]) busy_d[i_done_pe] = 1'b0;
    if (last_row) busy_d[cur_pe_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cur_pe_q  <= '0;
      rr_ptr_q  <= '0;
      row_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (err_hit) err_q <= 1'b1;
      if (accept) begin
        data_q  <= {i_data, row_cnt_q, pe_y(cur_pe_q), pe_x(cur_pe_q)};
        valid_q <= 1'b1;
      end else if (i_ready_noc) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (i_valid) state_q <= SELECT;
        SELECT: begin
          if (pick_found) begin
            cur_pe_q  <= pick_id;
            rr_ptr_q  <= rr_ptr_d;
            row_cnt_q <= '0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (row_cnt_q == '1) state_q <= i_valid ? SELECT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid_noc = valid_q;
  assign o_data_noc  = data_q;
  assign o_busy_pe   = busy_q;
  assign o_err       = err_q;

`ifdef DCT_DISPATCH_STATS_EN
  logic [31:0] blocks_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      blocks_q <= '0;
      stall_q  <= '0;
    end else begin
      if (last_row) blocks_q <= blocks_q + 32'd1;
      if (state_q == SELECT && !pick_found) stall_q <= stall_q + 32'd1;
    end
  end

  assign o_blocks_sent  = blocks_q;
  assign o_stall_cycles = stall_q;
`else
  assign o_blocks_sent  = '0;
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dct_block_dispatcher.sv
// Directed bench for dct_block_dispatcher: row/flit tables, PE assignment, stalls, backpressure, errors, reset.
module tb_dct_block_dispatcher;
  import dct_noc_pkg::*;

`ifdef DCT_DISPATCH_STATS_EN
  localparam bit statsOn = 1'b1;
`else
  localparam bit statsOn = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   i_valid = 1'b0;
  logic [data_width-1:0]  i_data = '0;
  logic                   o_ready;
  logic                   o_valid_noc;
  logic [total_width-1:0] o_data_noc;
  logic                   i_ready_noc = 1'b1;
  logic                   i_done_valid = 1'b0;
  logic [pe_w-1:0]        i_done_pe = '0;
  logic [pe_num-1:0]      o_busy_pe;
  logic                   o_err;
  logic [31:0]            o_blocks_sent;
  logic [31:0]            o_stall_cycles;

  int compared = 0;
  int mismatched = 0;
  logic [total_width-1:0] expQ[$];

  dct_block_dispatcher dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_valid_noc    (o_valid_noc),
    .o_data_noc     (o_data_noc),
    .i_ready_noc    (i_ready_noc),
    .i_done_valid   (i_done_valid),
    .i_done_pe      (i_done_pe),
    .o_busy_pe      (o_busy_pe),
    .o_err          (o_err),
    .o_blocks_sent  (o_blocks_sent),
    .o_stall_cycles (o_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0]           data;
    logic [total_width-1:0] flit;
  } rowVec_t;

  typedef struct {
    logic [255:0] base;
    int           pe;
    logic [3:0]   busy;
    int           blocks;
  } blockVec_t;

  task automatic checkOutput(input string name, input logic [total_width-1:0] actual,
                             input logic [total_width-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] expCnt(input int v);
    return statsOn ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [total_width-1:0] expFlit(input logic [255:0] d, input int pck, input int pe);
    logic [2:0] p;
    logic x;
    logic y;
    p = 3'(pck);
    x = 1'(pe % 2);
    y = 1'(pe / 2);
    return {d, p, y, x};
  endfunction

  // Flits are consumed on the edge after a negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (o_valid_noc && i_ready_noc) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_flit: got 0x%0h, expected none", o_data_noc);
      end else begin
        checkOutput("flit", o_data_noc, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [255:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_valid = 1'b1;
    i_data = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    compared++;
    if (!acc) begin
      mismatched++;
      $display("[TB] FAIL row_accept_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic sendBlock(input int pe, input logic [255:0] base);
    for (int r = 0; r < 8; r++) begin
      expQ.push_back(expFlit(base + 256'(r), r, pe));
      applyStimulus(base + 256'(r));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_empty", total_width'(expQ.size()), '0);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    i_valid = 1'b0;
    i_done_valid = 1'b0;
    i_ready_noc = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    expQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, total_width'(o_ready), '0);
    checkOutput({tag, "_valid"}, total_width'(o_valid_noc), '0);
    checkOutput({tag, "_data"}, o_data_noc, '0);
    checkOutput({tag, "_busy"}, total_width'(o_busy_pe), '0);
    checkOutput({tag, "_err"}, total_width'(o_err), '0);
    checkOutput({tag, "_blocks"}, total_width'(o_blocks_sent), '0);
    checkOutput({tag, "_stall"}, total_width'(o_stall_cycles), '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rowVec_t   rows[8];
    blockVec_t blocks[4];
    logic [255:0] base5;

    for (int i = 0; i < 8; i++) begin
      rows[i].data = 256'(i + 1);
      rows[i].flit = {256'(i + 1), 3'(i), 1'b0, 1'b0};
    end
    blocks[0] = '{256'h1000, 0, 4'b0001, 1};
    blocks[1] = '{256'h2000, 1, 4'b0011, 2};
    blocks[2] = '{256'h3000, 2, 4'b0111, 3};
    blocks[3] = '{256'h4000, 3, 4'b1111, 4};

    // Reset and a single block to PE 0
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back(rows[i].flit);
      applyStimulus(rows[i].data);
    end
    drain();
    checkOutput("t1_busy", total_width'(o_busy_pe), total_width'(4'b0001));
    checkOutput("t1_blocks", total_width'(o_blocks_sent), total_width'(expCnt(1)));

    // Four blocks back-to-back fill every PE in round-robin order
    doReset();
    for (int b = 0; b < 4; b++) begin
      sendBlock(blocks[b].pe, blocks[b].base);
      checkOutput("t2_busy", total_width'(o_busy_pe), total_width'(blocks[b].busy));
      checkOutput("t2_blocks", total_width'(o_blocks_sent), total_width'(expCnt(blocks[b].blocks)));
    end
    base5 = 256'h5000;
    i_valid = 1'b1;
    i_data = base5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_stall_ready", total_width'(o_ready), '0);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("t2_stall_cnt", total_width'(o_stall_cycles), total_width'(expCnt(5)));
    i_done_valid = 1'b1;
    i_done_pe = 2'd2;
    @(posedge clk);
    #1;
    i_done_valid = 1'b0;
    checkOutput("t2_busy_freed", total_width'(o_busy_pe), total_width'(4'b1011));
    sendBlock(2, base5);
    checkOutput("t2_busy_pe2", total_width'(o_busy_pe), total_width'(4'b1111));
    checkOutput("t2_blocks5", total_width'(o_blocks_sent), total_width'(expCnt(5)));
    checkOutput("t2_stall_final", total_width'(o_stall_cycles), total_width'(expCnt(6)));
    drain();

    // Completion for an idle PE raises a sticky error and leaves busy alone
    doReset();
    checkOutput("t3_err_init", total_width'(o_err), '0);
    i_done_valid = 1'b1;
    i_done_pe = 2'd1;
    @(posedge clk);
    #1;
    i_done_valid = 1'b0;
    checkOutput("t3_err_set", total_width'(o_err), total_width'(1'b1));
    checkOutput("t3_busy", total_width'(o_busy_pe), '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3_err_sticky", total_width'(o_err), total_width'(1'b1));
    doReset();
    checkOutput("t3_err_cleared", total_width'(o_err), '0);

    // Launch on PE 3 and completion of PE 0 on the same edge
    doReset();
    for (int b = 0; b < 3; b++) sendBlock(b, 256'h6000 + 256'(b * 256));
    for (int r = 0; r < 7; r++) begin
      expQ.push_back(expFlit(256'h7000 + 256'(r), r, 3));
      applyStimulus(256'h7000 + 256'(r));
    end
    expQ.push_back(expFlit(256'h7007, 7, 3));
    i_done_valid = 1'b1;
    i_done_pe = 2'd0;
    applyStimulus(256'h7007);
    i_done_valid = 1'b0;
    checkOutput("t4_busy_same", total_width'(o_busy_pe), total_width'(4'b1110));
    sendBlock(0, 256'h8000);
    checkOutput("t4_busy_after", total_width'(o_busy_pe), total_width'(4'b1111));
    checkOutput("t4_err", total_width'(o_err), '0);
    drain();

    // NoC backpressure mid-block holds a single flit
    doReset();
    for (int r = 0; r < 3; r++) begin
      expQ.push_back(expFlit(256'h9000 + 256'(r), r, 0));
      applyStimulus(256'h9000 + 256'(r));
    end
    i_ready_noc = 1'b0;
    i_valid = 1'b1;
    i_data = 256'h9003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_hold_ready", total_width'(o_ready), '0);
      checkOutput("t5_hold_valid", total_width'(o_valid_noc), total_width'(1'b1));
      checkOutput("t5_hold_data", o_data_noc, expFlit(256'h9002, 2, 0));
      @(posedge clk);
    end
    #1;
    i_ready_noc = 1'b1;
    for (int r = 3; r < 8; r++) begin
      expQ.push_back(expFlit(256'h9000 + 256'(r), r, 0));
      applyStimulus(256'h9000 + 256'(r));
    end
    drain();
    checkOutput("t5_busy", total_width'(o_busy_pe), total_width'(4'b0001));

    // Reset in the middle of a block discards it
    doReset();
    for (int r = 0; r < 4; r++) begin
      expQ.push_back(expFlit(256'hA000 + 256'(r), r, 0));
      applyStimulus(256'hA000 + 256'(r));
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("midrst");
    checkOutput("midrst_flushed", total_width'(expQ.size()), '0);
    rstn = 1'b1;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_no_flit", total_width'(o_valid_noc), '0);
    sendBlock(0, 256'hB000);
    drain();
    checkOutput("midrst_busy", total_width'(o_busy_pe), total_width'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dct_block_dispatcher.md
# dct_block_dispatcher

Sequences DCT work onto the NoC: accepts 256-bit image rows from the PCIe-side stream, groups every 8 consecutive rows into one DCT block, and assigns each block to a free processing element in round-robin order. Each row becomes one NoC flit tagged with the destination x/y and the row number. It sits inside procTop between the PCIe input handshake and the root PE's NoC injection port. A per-PE busy bitmap, released by completion reports from the result path, limits each PE to one block in flight.

## Interface
- X, 2, mesh columns
- Y, 2, mesh rows
- data_width, 256, row/payload width
- pck_num, 3, packet-number field width (row index 0..7)
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- i_valid  in  1  PCIe row valid
- i_data  in  data_width  PCIe row
- o_ready  out  1  row accepted when i_valid & o_ready
- o_valid_noc  out  1  flit valid toward NoC
- o_data_noc  out  $clog2(X)+$clog2(Y)+pck_num+data_width  flit {row, pck_no, y, x}, x in LSBs
- i_ready_noc  in  1  NoC accepts flit
- i_done_valid  in  1  a PE finished its block
- i_done_pe  in  $clog2(X*Y)  id of finished PE (id = y*X + x)
- o_busy_pe  out  X*Y  registered busy bitmap
- o_err  out  1  sticky: done reported for a non-busy PE
- o_blocks_sent  out  32  blocks fully dispatched
- o_stall_cycles  out  32  cycles in SELECT with no free PE

## Operation
- States: IDLE, SELECT, STREAM.
- IDLE: o_ready=0; i_valid=1 -> SELECT.
- SELECT: o_ready=0; if any busy bit is 0, latch cur_pe = first free id at or after rr_ptr (wrapping modulo X*Y), rr_ptr <= cur_pe+1 (wraps to 0), row_cnt <= 0, -> STREAM; otherwise stay and increment o_stall_cycles.
- STREAM: o_ready = !o_valid_noc | i_ready_noc. On each accepted row: o_data_noc <= {i_data, row_cnt, cur_pe/X, cur_pe%X}, o_valid_noc <= 1, row_cnt++. On acceptance with row_cnt==7: busy[cur_pe] <= 1, o_blocks_sent++, -> SELECT if i_valid else IDLE.
- o_valid_noc clears on i_ready_noc when no new row is accepted that cycle; the flit holds stable while i_ready_noc=0.
- i_done_valid: busy[i_done_pe] <= 0. If that bit is already 0, it is ignored and o_err <= 1.
- Set and clear of different PEs in one cycle: both apply. SELECT uses registered busy, so a PE freed this cycle is eligible from the next cycle.
- Counters wrap at 2^32.

## Timing
- Reset (rstn=0 at edge): state=IDLE, o_ready=0, o_valid_noc=0, o_data_noc=0, o_busy_pe=0, o_err=0, rr_ptr=0, row_cnt=0, both counters=0. Reset mid-block drops the partial block; no further flits are emitted for it.
- Latency: row accepted at edge N -> flit valid after edge N.
- Block overhead: one SELECT cycle between blocks, so minimum 9 cycles per block at full throughput.
- Full backpressure: with i_ready_noc=0, at most one row is held and o_ready=0.

## Configuration
- DCT_DISPATCH_STATS_EN defined: o_blocks_sent and o_stall_cycles count as specified.
- Not defined: the counter registers are omitted; both ports are tied to 0. All other behaviour is identical.

## Structure
- Shared package dct_noc_pkg: X/Y defaults, data_width, pck_num, derived widths (x_size, y_size, total_width, pe_id width), state enum, id-to-x/y helper.
- Sub-module rr_free_picker: combinational first-zero finder over the busy vector, starting at rr_ptr with wrap; outputs found and id.

## Test plan
- Reset, then 8 rows 0x01..0x08 with i_ready_noc=1 -> 8 flits to PE 0 (x=0,y=0), pck_no 0..7, busy=4'b0001, blocks_sent=1.
- 4 blocks back-to-back, no done reports -> PE ids 0,1,2,3 (x/y (0,0),(1,0),(0,1),(1,1)). A 5th block stalls in SELECT with o_ready=0 and stall_cycles incrementing. Done for PE 2 -> 5th block goes to PE 2.
- i_ready_noc=0 for 5 cycles mid-block -> flit held stable, no rows lost, row order preserved.
- Done for PE 1 while busy=0 -> o_err=1, sticky until reset; busy unchanged.
- Same cycle: last row of block to PE 3 plus done for PE 0 -> busy[3] set and busy[0] cleared together. Next SELECT with rr_ptr=0 picks PE 0.
- rstn low after row 4 of a block -> all outputs reach reset values; next block starts at PE 0 with pck_no 0.
